// File: rtl/sram_rw_port_arbiter.sv
// sram_rw_port_arbiter: round-robin two-client arbiter for the SRAM RW port, with optional clear sweep.
// Define SRAM_ARB_STATS_EN to add saturating per-client acceptance counters.
module sram_rw_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  a_rsp_valid,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic                  sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [15:0]           a_grant_cnt,
    output logic [15:0]           b_grant_cnt
`endif
);
    typedef enum logic {INIT, RUN} state_t;
    state_t state;
    logic [ADDR_WIDTH:0] cnt;
    logic rr;
    logic gnt_b, acc, sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [1:0] rd0, rd1;
    always_comb begin
        gnt_b = b_valid && (!a_valid || rr);
        a_ready = (state == RUN) && a_valid && !gnt_b;
        b_ready = (state == RUN) && gnt_b;
        acc = a_ready || b_ready;
        sel_we = gnt_b ? b_we : a_we;
        sel_addr = gnt_b ? b_addr : a_addr;
        sel_wdata = gnt_b ? b_wdata : a_wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt <= '0;
            rr <= 1'b0;
            init_done <= 1'b0;
            sram_csb0 <= 1'b1;
            sram_web0 <= 1'b1;
            sram_wmask0 <= 1'b0;
            sram_addr0 <= '0;
            sram_din0 <= '0;
            rd0 <= '0;
            rd1 <= '0;
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            sram_csb0 <= 1'b1;
            sram_web0 <= 1'b1;
            sram_wmask0 <= 1'b0;
            // {valid, client id} of reads in flight; id 1 = client B
            rd0 <= {acc && !sel_we, gnt_b};
            rd1 <= rd0;
            a_rsp_valid <= rd1[1] && !rd1[0];
            b_rsp_valid <= rd1[1] && rd1[0];
            if (rd1[1]) rsp_rdata <= sram_dout0;
            if (state == INIT) begin
                if (!CLEAR_ON_RESET || cnt[ADDR_WIDTH]) begin
                    state <= RUN;
                    init_done <= 1'b1;
                end else begin
                    sram_csb0 <= 1'b0;
                    sram_web0 <= 1'b0;
                    sram_wmask0 <= 1'b1;
                    sram_addr0 <= cnt[ADDR_WIDTH-1:0];
                    sram_din0 <= INIT_VALUE;
                    cnt <= cnt + (ADDR_WIDTH+1)'(1);
                end
            end else if (acc) begin
                sram_csb0 <= 1'b0;
                sram_web0 <= !sel_we;
                sram_wmask0 <= sel_we;
                sram_addr0 <= sel_addr;
                sram_din0 <= sel_wdata;
                rr <= !gnt_b;
            end
        end
    end
`ifdef SRAM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            a_grant_cnt <= '0;
            b_grant_cnt <= '0;
        end else begin
            if (a_ready && a_grant_cnt != 16'hFFFF) a_grant_cnt <= a_grant_cnt + 16'd1;
            if (b_ready && b_grant_cnt != 16'hFFFF) b_grant_cnt <= b_grant_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_sram_rw_port_arbiter.sv
// tb_sram_rw_port_arbiter: vector table plus reset/sweep sequences, with a behavioural SRAM macro.
module tb_sram_rw_port_arbiter;
    logic clk = 1'b0, rst = 1'b1;
    logic a_valid = 0, a_we = 0, b_valid = 0, b_we = 0;
    logic [9:0] a_addr = 0, b_addr = 0;
    logic [7:0] a_wdata = 0, b_wdata = 0;
    logic a_ready, b_ready, a_rsp_valid, b_rsp_valid, init_done;
    logic [7:0] rsp_rdata, sram_din0, sram_dout0;
    logic sram_csb0, sram_web0, sram_wmask0;
    logic [9:0] sram_addr0;
`ifdef SRAM_ARB_STATS_EN
    logic [15:0] a_grant_cnt, b_grant_cnt;
`endif
    int n_cmp = 0, n_err = 0;

    sram_rw_port_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_rsp_valid(a_rsp_valid), .b_rsp_valid(b_rsp_valid), .rsp_rdata(rsp_rdata),
        .init_done(init_done), .sram_csb0(sram_csb0), .sram_web0(sram_web0),
        .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
        .sram_dout0(sram_dout0)
`ifdef SRAM_ARB_STATS_EN
        , .a_grant_cnt(a_grant_cnt), .b_grant_cnt(b_grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Macro model: pins sampled at posedge, write committed / read data driven at the following negedge
    logic [7:0] mem [1024];
    logic cs_q = 0, we_q = 0;
    logic [9:0] ad_q = 0;
    logic [7:0] di_q = 0;
    initial begin
        sram_dout0 = 8'h00;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h3C;
    end
    always @(posedge clk) begin
        cs_q <= !sram_csb0;
        we_q <= !sram_web0 && sram_wmask0;
        ad_q <= sram_addr0;
        di_q <= sram_din0;
    end
    always @(negedge clk) if (cs_q) begin
        if (we_q) mem[ad_q] <= di_q;
        else sram_dout0 <= mem[ad_q];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic reset_sweep();
        int n = 0;
        logic rdy_bad = 1'b0;
        rst = 1'b1;
        a_valid = 1; b_valid = 1; a_we = 0; b_we = 0;
        for (int e = 0; e < 2; e++) begin
            @(posedge clk); #1;
            chk($sformatf("rst%0d rsp_valid", e), 32'({a_rsp_valid, b_rsp_valid}), 0);
        end
        chk("rst ready", 32'({a_ready, b_ready}), 0);
        chk("rst init_done", 32'(init_done), 0);
        chk("rst pins", 32'({sram_csb0, sram_web0, sram_wmask0}), 32'b110);
        chk("rst addr/din", 32'({sram_addr0, sram_din0}), 0);
        chk("rst rdata", 32'(rsp_rdata), 0);
        rst = 1'b0;
        for (int c = 1; c <= 1100; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                chk("sweep first pins", 32'({sram_csb0, sram_web0, sram_wmask0}), 32'b001);
                chk("sweep first addr/din", 32'({sram_addr0, sram_din0}), 0);
            end
            if (init_done) begin n = c; break; end
            if (a_ready || b_ready) rdy_bad = 1'b1;
        end
        chk("sweep ready low", 32'(rdy_bad), 0);
        chk("sweep length", n, 1025);
        a_valid = 0; b_valid = 0;
    endtask

    typedef struct {
        int av, aw, aa, ad, bv, bw, ba, bd;
        int ear, ebr, ecsb, eweb, ewm, eaddr, edin, eas, ebs, erd;
    } vec_t;
    vec_t vecs [22];

    initial begin
        vecs = '{
            '{1,1,'h123,'hA5, 0,0,0,0,        1,0, 0,0,1,'h123,'hA5, 0,0,0},
            '{1,0,'h123,0,    0,0,0,0,        1,0, 0,1,0,'h123,0,    0,0,0},
            '{0,0,0,0,        0,0,0,0,        0,0, 1,1,0,'h123,0,    0,0,0},
            '{0,0,0,0,        1,1,'h200,'h3C, 0,1, 0,0,1,'h200,'h3C, 1,0,'hA5},
            '{1,0,'h123,0,    1,0,'h200,0,    1,0, 0,1,0,'h123,0,    0,0,0},
            '{1,0,'h123,0,    1,0,'h200,0,    0,1, 0,1,0,'h200,0,    0,0,0},
            '{1,0,'h123,0,    1,0,'h200,0,    1,0, 0,1,0,'h123,0,    1,0,'hA5},
            '{1,0,'h123,0,    1,0,'h200,0,    0,1, 0,1,0,'h200,0,    0,1,'h3C},
            '{1,0,'h123,0,    1,0,'h200,0,    1,0, 0,1,0,'h123,0,    1,0,'hA5},
            '{1,0,'h123,0,    1,0,'h200,0,    0,1, 0,1,0,'h200,0,    0,1,'h3C},
            '{0,0,0,0,        1,0,'h200,0,    0,1, 0,1,0,'h200,0,    1,0,'hA5},
            '{0,0,0,0,        1,1,'h201,'h77, 0,1, 0,0,1,'h201,'h77, 0,1,'h3C},
            '{0,0,0,0,        1,0,'h201,0,    0,1, 0,1,0,'h201,0,    0,1,'h3C},
            '{0,0,0,0,        1,0,'h123,0,    0,1, 0,1,0,'h123,0,    0,0,0},
            '{0,0,0,0,        0,0,0,0,        0,0, 1,1,0,'h123,0,    0,1,'h77},
            '{0,0,0,0,        0,0,0,0,        0,0, 1,1,0,'h123,0,    0,1,'hA5},
            '{1,0,'h000,0,    0,0,0,0,        1,0, 0,1,0,'h000,0,    0,0,0},
            '{1,0,'h1FF,0,    0,0,0,0,        1,0, 0,1,0,'h1FF,0,    0,0,0},
            '{1,0,'h3FF,0,    0,0,0,0,        1,0, 0,1,0,'h3FF,0,    1,0,'h00},
            '{1,1,'h005,'h11, 1,1,'h006,'h22, 0,1, 0,0,1,'h006,'h22, 1,0,'h00},
            '{0,0,0,0,        0,0,0,0,        0,0, 1,1,0,'h006,'h22, 1,0,'h00},
            '{0,0,0,0,        0,0,0,0,        0,0, 1,1,0,'h006,'h22, 0,0,0}
        };
        reset_sweep();
        for (int i = 0; i < 22; i++) begin
            a_valid = 1'(vecs[i].av); a_we = 1'(vecs[i].aw);
            a_addr = 10'(vecs[i].aa); a_wdata = 8'(vecs[i].ad);
            b_valid = 1'(vecs[i].bv); b_we = 1'(vecs[i].bw);
            b_addr = 10'(vecs[i].ba); b_wdata = 8'(vecs[i].bd);
            #1;
            chk($sformatf("row%0d ready", i), 32'({a_ready, b_ready}), 32'({1'(vecs[i].ear), 1'(vecs[i].ebr)}));
            @(posedge clk); #1;
            chk($sformatf("row%0d csb/web/wmask", i), 32'({sram_csb0, sram_web0, sram_wmask0}),
                32'({1'(vecs[i].ecsb), 1'(vecs[i].eweb), 1'(vecs[i].ewm)}));
            chk($sformatf("row%0d addr", i), 32'(sram_addr0), vecs[i].eaddr);
            chk($sformatf("row%0d din", i), 32'(sram_din0), vecs[i].edin);
            chk($sformatf("row%0d rsp_valid", i), 32'({a_rsp_valid, b_rsp_valid}),
                32'({1'(vecs[i].eas), 1'(vecs[i].ebs)}));
            if (vecs[i].eas != 0 || vecs[i].ebs != 0)
                chk($sformatf("row%0d rdata", i), 32'(rsp_rdata), vecs[i].erd);
        end
        a_valid = 0; b_valid = 0;
        // Two reads in flight (B then A, leaving rr at B), then reset one cycle later
        b_valid = 1; b_we = 0; b_addr = 10'h200;
        #1; chk("midrst b_ready", 32'(b_ready), 1);
        @(posedge clk); #1;
        b_valid = 0; a_valid = 1; a_we = 0; a_addr = 10'h123;
        #1; chk("midrst a_ready", 32'(a_ready), 1);
        @(posedge clk); #1;
        reset_sweep();
        a_valid = 1; b_valid = 1; a_we = 0; b_we = 0;
        #1; chk("rr reset to A", 32'({a_ready, b_ready}), 32'b10);
        @(posedge clk); #1;
        a_valid = 0; b_valid = 0;
`ifdef SRAM_ARB_STATS_EN
        reset_sweep();
        chk("stats cleared", 32'({a_grant_cnt, b_grant_cnt}), 0);
        a_valid = 1; a_we = 0; a_addr = 10'h000;
        repeat (70000) @(posedge clk);
        #1;
        a_valid = 0;
        chk("a_grant_cnt sat", 32'(a_grant_cnt), 32'hFFFF);
        chk("b_grant_cnt", 32'(b_grant_cnt), 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
